// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer for the accumulator processor: fetches,
// decodes and drives datapath selects/enables and data-RAM strobes.
module control_unit #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_OPCODE      = 5,
  parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
  parameter int NB_SELECTOR_A  = 2,
  parameter int NB_COUNTER     = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  output logic [NB_ADDR-1:0]        o_pc,
  output logic                      o_prog_rd,
  output logic [NB_ADDR-1:0]        o_data_addr,
  output logic [NB_OPERAND-1:0]     o_operand,
  output logic                      o_rd_ram,
  output logic                      o_wr_ram,
  output logic [NB_SELECTOR_A-1:0]  o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_operation,
  output logic                      o_enb_acc,
  output logic                      o_halted,
  output logic [NB_COUNTER-1:0]     o_clk_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  state_t                    r_state;
  logic [NB_ADDR-1:0]        r_pc;
  logic [NB_INSTRUCTION-1:0] r_ir;
  logic [NB_COUNTER-1:0]     r_count;

  logic [NB_OPCODE-1:0] w_fetch_opcode;
  logic [NB_OPCODE-1:0] w_ir_opcode;
  logic                 w_active;

  assign w_fetch_opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign w_ir_opcode    = r_ir[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign w_active       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                          (r_state == S_MEM)   || (r_state == S_EXEC);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      // Saturating count of cycles spent executing instructions.
      if (w_active && (r_count != '1)) begin
        r_count <= r_count + NB_COUNTER'(1);
      end
      case (r_state)
        S_IDLE:   if (i_start) r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= i_instruction;
          // Route on the incoming word, since IR only holds it from the next cycle.
          case (w_fetch_opcode)
            OP_HLT:                r_state <= S_HALT;
            OP_LD, OP_ADD, OP_SUB: r_state <= S_MEM;
            default:               r_state <= S_EXEC;
          endcase
        end
        S_MEM:    r_state <= S_EXEC;
        S_EXEC: begin
          r_pc    <= r_pc + NB_ADDR'(1);
          r_state <= S_FETCH;
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_pc        = r_pc;
    o_data_addr = r_ir[NB_ADDR-1:0];
    o_operand   = r_ir[NB_OPERAND-1:0];
    o_clk_count = r_count;
    o_prog_rd   = (r_state == S_FETCH);
    o_rd_ram    = (r_state == S_MEM);
    o_halted    = (r_state == S_HALT);
    o_wr_ram    = 1'b0;
    o_sel_a     = '0;
    o_sel_b     = 1'b0;
    o_operation = 1'b0;
    o_enb_acc   = 1'b0;
    // Adder inputs settle during MEM so they are stable before the EXEC enable.
    if ((r_state == S_MEM) || (r_state == S_EXEC)) begin
      o_sel_b     = (w_ir_opcode == OP_ADDI) || (w_ir_opcode == OP_SUBI);
      o_operation = (w_ir_opcode == OP_SUB)  || (w_ir_opcode == OP_SUBI);
    end
    if (r_state == S_EXEC) begin
      case (w_ir_opcode)
        OP_STO: o_wr_ram = 1'b1;
        OP_LD:  o_enb_acc = 1'b1;
        OP_LDI: begin
          o_sel_a   = NB_SELECTOR_A'(1);
          o_enb_acc = 1'b1;
        end
        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
          o_sel_a   = NB_SELECTOR_A'(2);
          o_enb_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle comparison against a trace generated from
// the instruction-level execution rules, plus directed program scenarios.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [15:0] i_instruction;
  logic [10:0] o_pc;
  logic        o_prog_rd;
  logic [10:0] o_data_addr;
  logic [10:0] o_operand;
  logic        o_rd_ram;
  logic        o_wr_ram;
  logic [1:0]  o_sel_a;
  logic        o_sel_b;
  logic        o_operation;
  logic        o_enb_acc;
  logic        o_halted;
  logic [31:0] o_clk_count;

  control_unit dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_instruction(i_instruction),
    .o_pc(o_pc), .o_prog_rd(o_prog_rd), .o_data_addr(o_data_addr), .o_operand(o_operand),
    .o_rd_ram(o_rd_ram), .o_wr_ram(o_wr_ram), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
    .o_operation(o_operation), .o_enb_acc(o_enb_acc), .o_halted(o_halted),
    .o_clk_count(o_clk_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] pc;
    logic        prog_rd;
    logic [10:0] data_addr;
    logic [10:0] operand;
    logic        rd_ram;
    logic        wr_ram;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        enb;
    logic        halted;
    logic [31:0] cnt;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);
  localparam logic [15:0] NOP_WORD = 16'hF800;

  logic [15:0]      prog [0:2047];
  logic [OBS_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Per-run observations, cycle numbers counted with the start cycle as 1.
  int          enb_cyc[$];
  int          rd_cyc[$];
  logic [10:0] rd_addr[$];
  logic [10:0] wr_addr[$];
  logic [3:0]  enb_sel[$];
  int          halt_cyc;
  logic [10:0] halt_pc;
  logic [31:0] halt_cnt;

  // Program memory: one-cycle read latency after o_prog_rd.
  always @(posedge clk) if (o_prog_rd) i_instruction <= prog[o_pc];

  function automatic obs_t sample();
    obs_t o;
    o.pc = o_pc; o.prog_rd = o_prog_rd; o.data_addr = o_data_addr; o.operand = o_operand;
    o.rd_ram = o_rd_ram; o.wr_ram = o_wr_ram; o.sel_a = o_sel_a; o.sel_b = o_sel_b;
    o.op = o_operation; o.enb = o_enb_acc; o.halted = o_halted; o.cnt = o_clk_count;
    return o;
  endfunction

  function automatic obs_t base_obs(logic [10:0] pc, logic [15:0] ir, logic [31:0] cnt);
    obs_t o;
    o = '0;
    o.pc = pc; o.data_addr = ir[10:0]; o.operand = ir[10:0]; o.cnt = cnt;
    return o;
  endfunction

  // Expected per-cycle trace from the instruction rules; with patch set, address 0
  // reads as HLT once execution has wrapped past 0x7FF.
  task automatic build_trace(input bit patch);
    logic [10:0] pc = '0;
    logic [15:0] ir = '0;
    logic [15:0] w;
    logic [31:0] cnt = '0;
    logic [4:0]  opc;
    bit          wrapped = 0;
    bit          done = 0;
    int          guard = 0;
    obs_t        o;
    exp_q.delete();
    while (!done && guard < 20000) begin
      guard++;
      w   = (patch && wrapped && pc == 11'd0) ? 16'h0000 : prog[pc];
      opc = w[15:11];
      o = base_obs(pc, ir, cnt); o.prog_rd = 1'b1; exp_q.push_back(o); cnt++;
      o = base_obs(pc, ir, cnt); exp_q.push_back(o); cnt++;
      ir = w;
      if (opc == 5'd0) begin
        o = base_obs(pc, ir, cnt); o.halted = 1'b1;
        repeat (3) exp_q.push_back(o);
        done = 1;
      end else begin
        if (opc inside {5'd2, 5'd4, 5'd6}) begin
          o = base_obs(pc, ir, cnt); o.rd_ram = 1'b1; o.op = (opc == 5'd6);
          exp_q.push_back(o); cnt++;
        end
        o = base_obs(pc, ir, cnt);
        case (opc)
          5'd1: o.wr_ram = 1'b1;
          5'd2: o.enb = 1'b1;
          5'd3: begin o.sel_a = 2'b01; o.enb = 1'b1; end
          5'd4, 5'd5, 5'd6, 5'd7: begin
            o.sel_a = 2'b10; o.sel_b = opc[0]; o.op = opc[1]; o.enb = 1'b1;
          end
          default: ;
        endcase
        exp_q.push_back(o); cnt++;
        if (pc == 11'h7FF) wrapped = 1;
        pc = pc + 11'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b0; i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
  endtask

  task automatic clear_prog(input logic [15:0] fill);
    for (int a = 0; a < 2048; a++) prog[a] = fill;
  endtask

  // Runs prog from reset, comparing every cycle to the model trace.
  task automatic run_program(input bit patch, input bit hold_start);
    obs_t got, exp;
    int   idx = 0;
    build_trace(patch);
    enb_cyc.delete(); rd_cyc.delete(); rd_addr.delete(); wr_addr.delete(); enb_sel.delete();
    halt_cyc = -1; halt_pc = 'x; halt_cnt = 'x;
    do_reset();
    i_start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      got = sample();
      exp = obs_t'(exp_q.pop_front());
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL trace cycle=%0d got=%h expected=%h", idx + 2, got, exp);
        exp_q.delete();
      end
      if (got.enb) begin enb_cyc.push_back(idx + 2); enb_sel.push_back({got.sel_a, got.sel_b, got.op}); end
      if (got.rd_ram) begin rd_cyc.push_back(idx + 2); rd_addr.push_back(got.data_addr); end
      if (got.wr_ram) wr_addr.push_back(got.data_addr);
      if (got.halted && halt_cyc < 0) begin
        halt_cyc = idx + 2; halt_pc = got.pc; halt_cnt = got.cnt;
        i_start = 1'b1;
      end
      if (patch && got.pc == 11'h7FF) prog[0] = 16'h0000;
      if (!hold_start && idx == 0) i_start = 1'b0;
      idx++;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_reset = 1'b0; i_start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (sample() !== obs_t'('0)) begin
        failures++; $display("FAIL reset_hold got=%h expected=0", sample());
      end
    end
    @(negedge clk);
    i_reset = 1'b1; i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (o_prog_rd !== 1'b0 || sample() !== obs_t'('0)) begin
        failures++; $display("FAIL idle_no_start got=%h expected=0", sample());
      end
    end
  endtask

  task automatic test_immediate();
    clear_prog(16'h0000);
    prog[0] = {5'd3, 11'd5};
    prog[1] = {5'd5, 11'h7FE};
    prog[2] = {5'd7, 11'd1};
    prog[3] = 16'h0000;
    run_program(0, 1);
    checks++;
    if (enb_cyc.size() != 3) begin
      failures++; $display("FAIL imm_enb_count got=%0d expected=3", enb_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (enb_cyc[k] != 4 + 3 * k) begin
          failures++; $display("FAIL imm_enb_cycle%0d got=%0d expected=%0d", k, enb_cyc[k], 4 + 3 * k);
        end
      end
      checks++;
      if (enb_sel[0][3:2] !== 2'b01 || enb_sel[1] !== 4'b1010 || enb_sel[2] !== 4'b1011) begin
        failures++;
        $display("FAIL imm_selects got=%b/%b/%b expected=01xx/1010/1011", enb_sel[0], enb_sel[1], enb_sel[2]);
      end
    end
    checks++;
    if (halt_cyc != 13 || halt_pc !== 11'd3 || halt_cnt !== 32'd11) begin
      failures++;
      $display("FAIL imm_halt got cyc=%0d pc=%0d cnt=%0d expected cyc=13 pc=3 cnt=11", halt_cyc, halt_pc, halt_cnt);
    end
  endtask

  task automatic test_memory();
    clear_prog(16'h0000);
    prog[0] = {5'd2, 11'h010};
    prog[1] = {5'd4, 11'h011};
    prog[2] = {5'd6, 11'h012};
    prog[3] = {5'd1, 11'h013};
    prog[4] = 16'h0000;
    run_program(0, 0);
    checks++;
    if (rd_cyc.size() != 3 || enb_cyc.size() != 3) begin
      failures++; $display("FAIL mem_pulses got rd=%0d enb=%0d expected rd=3 enb=3", rd_cyc.size(), enb_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_cyc[k] + 1 != enb_cyc[k] || rd_addr[k] !== 11'h010 + 11'(k)) begin
          failures++;
          $display("FAIL mem_rd%0d got rd_cyc=%0d enb_cyc=%0d addr=%h expected addr=%h", k, rd_cyc[k], enb_cyc[k], rd_addr[k], 11'h010 + 11'(k));
        end
      end
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 11'h013) begin
      failures++; $display("FAIL mem_store got writes=%0d expected 1 at 013", wr_addr.size());
    end
    checks++;
    if (halt_cnt !== 32'd17) begin
      failures++; $display("FAIL mem_count got=%0d expected=17", halt_cnt);
    end
  endtask

  task automatic test_undefined();
    clear_prog(16'h0000);
    prog[0] = {5'b11111, 11'($urandom_range(0, 2047))};
    run_program(0, 1);
    checks++;
    if (enb_cyc.size() + rd_cyc.size() + wr_addr.size() != 0 || halt_pc !== 11'd1) begin
      failures++;
      $display("FAIL nop got strobes=%0d halt_pc=%0d expected strobes=0 halt_pc=1", enb_cyc.size() + rd_cyc.size() + wr_addr.size(), halt_pc);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int len;
      len = $urandom_range(6, 14);
      clear_prog(16'h0000);
      for (int a = 0; a < len; a++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        prog[a] = {opc, 11'($urandom_range(0, 2047))};
      end
      run_program(0, p[0]);
      checks++;
      if (halt_pc !== 11'(len)) begin
        failures++; $display("FAIL random%0d_halt_pc got=%0d expected=%0d", p, halt_pc, len);
      end
    end
  endtask

  task automatic test_pc_wrap();
    clear_prog(NOP_WORD);
    run_program(1, 0);
    checks++;
    if (halt_pc !== 11'd0 || halt_cnt !== 32'd6146 || halt_cyc < 0) begin
      failures++; $display("FAIL pc_wrap got pc=%h cnt=%0d expected pc=000 cnt=6146", halt_pc, halt_cnt);
    end
    prog[0] = NOP_WORD;
  endtask

  task automatic test_reset_mid_mem();
    obs_t exp;
    bit   found = 0;
    bit   saw_enb = 0;
    clear_prog(16'h0000);
    prog[0] = {5'd4, 11'h011};
    do_reset();
    i_start = 1'b1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      if (o_enb_acc) saw_enb = 1;
      if (o_rd_ram) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midmem_reach got=no_rd_ram expected=rd_ram"); end
    i_reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sample() !== obs_t'('0)) begin failures++; $display("FAIL midmem_clear got=%h expected=0", sample()); end
    i_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (o_enb_acc) saw_enb = 1;
    end
    checks++;
    if (saw_enb) begin failures++; $display("FAIL midmem_enb got=pulse expected=none"); end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    exp = base_obs(11'd0, 16'h0000, 32'd0); exp.prog_rd = 1'b1;
    checks++;
    if (sample() !== exp) begin failures++; $display("FAIL midmem_refetch got=%h expected=%h", sample(), exp); end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_instruction = '0;
    test_reset();
    test_immediate();
    test_memory();
    test_undefined();
    test_random();
    test_pc_wrap();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the accumulator processor. It fetches 16-bit instructions from program memory and decodes the 5-bit opcode. It drives the datapath control inputs (mux selects, accumulator enable, add/sub) and the data-RAM strobes. It sits between program memory, data memory and the datapath, as the initiator of the datapath's control interface.

## Interface
- NB_INSTRUCTION, 16, instruction width
- NB_ADDR, 11, program/data address width
- NB_OPCODE, 5, opcode width (instruction MSBs)
- NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand width (instruction LSBs)
- NB_SELECTOR_A, 2, datapath mux A select width
- NB_COUNTER, 32, cycle counter width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  begin execution from address 0; sampled only in IDLE
- i_instruction  in  NB_INSTRUCTION  program memory read data, valid the cycle after o_prog_rd
- o_pc  out  NB_ADDR  program memory address
- o_prog_rd  out  1  program memory read strobe
- o_data_addr  out  NB_ADDR  data RAM address = IR[NB_ADDR-1:0]
- o_operand  out  NB_OPERAND  IR[NB_OPERAND-1:0], to datapath operand input
- o_rd_ram  out  1  data RAM read strobe (1-cycle read latency)
- o_wr_ram  out  1  data RAM write strobe (data comes from datapath accumulator)
- o_sel_a  out  NB_SELECTOR_A  00 RAM data, 01 sign-extended operand, 10 adder result
- o_sel_b  out  1  0 RAM data, 1 sign-extended operand
- o_operation  out  1  0 add, 1 sub
- o_enb_acc  out  1  accumulator load enable
- o_halted  out  1  HLT executed
- o_clk_count  out  NB_COUNTER  executed-cycle count

## Operation
- Registers: state, PC (NB_ADDR), IR (NB_INSTRUCTION), cycle counter. Outputs are Moore, decoded from state and IR.
- States:
  - IDLE: everything deasserted. i_start=1 moves to FETCH.
  - FETCH: o_prog_rd=1, o_pc=PC. Next state DECODE.
  - DECODE: IR <= i_instruction. Next state follows IR opcode:
    - HLT goes to HALT.
    - LD/ADD/SUB go to MEM.
    - All others go to EXEC.
  - MEM: o_rd_ram=1. Next state EXEC.
  - EXEC: PC <= PC+1 (wraps 2^NB_ADDR-1 to 0). Next state FETCH.
  - HALT: o_halted=1. Held until reset; i_start is ignored.
- Opcodes, with EXEC outputs:
  - 00000 HLT.
  - 00001 STO: o_wr_ram=1.
  - 00010 LD: sel_a=00, enb=1.
  - 00011 LDI: sel_a=01, enb=1.
  - 00100 ADD: sel_a=10, sel_b=0, op=0, enb=1.
  - 00101 ADDI: sel_a=10, sel_b=1, op=0, enb=1.
  - 00110 SUB: sel_a=10, sel_b=0, op=1, enb=1.
  - 00111 SUBI: sel_a=10, sel_b=1, op=1, enb=1.
- Undefined opcodes execute as NOP: they pass through EXEC with no strobes or enables, and PC increments.
- o_sel_b and o_operation hold their EXEC values during MEM as well, so datapath inputs are settled before the enable.
- o_data_addr and o_operand follow IR in every state.
- Cycle counter: +1 every cycle in FETCH/DECODE/MEM/EXEC. Frozen in IDLE and HALT. Saturates at all-ones with no wrap.

## Timing
- Reset (i_reset=0 at an edge) takes effect that edge, including mid-instruction.
- Reset values: state=IDLE, PC=0, IR=0, count=0.
- Output reset values:
  - o_pc=0, o_data_addr=0, o_operand=0, o_sel_a=00.
  - o_prog_rd, o_rd_ram, o_wr_ram, o_sel_b, o_operation, o_enb_acc and o_halted all 0.
- A store in progress at reset is not written.
- Latency from IDLE+i_start to the first FETCH: 1 cycle.
- Cycles per instruction:
  - Immediate ops, STO and NOP: 3 (FETCH, DECODE, EXEC).
  - LD/ADD/SUB: 4 (FETCH, DECODE, MEM, EXEC).
  - HLT: 2 to reach HALT, and PC does not increment.
- o_enb_acc and o_wr_ram are single-cycle pulses, only in EXEC.
- o_rd_ram is a single-cycle pulse, only in MEM.
- i_start held high after leaving IDLE has no effect.

## Test plan
- Reset: hold i_reset=0 for 2 cycles with i_start=1. All outputs must be 0 and state IDLE. Release reset; with i_start=0 for 5 cycles, o_prog_rd stays 0.
- Immediate program: program LDI 5, ADDI -2 (operand 0x7FE), SUBI 1, HLT. Required response:
  - o_enb_acc pulses at cycles 4, 7 and 10 after start.
  - Selects are 01/-/-, then 10/1/0, then 10/1/1.
  - o_halted rises at cycle 13, o_pc=3 at halt, and o_clk_count=11.
- Memory program: program LD 0x010, ADD 0x011, SUB 0x012, STO 0x013, HLT. Required response:
  - Each of LD/ADD/SUB shows o_rd_ram one cycle before o_enb_acc, with o_data_addr=0x010/0x011/0x012.
  - STO shows o_wr_ram=1 for exactly 1 cycle with o_data_addr=0x013.
  - o_clk_count=17 at halt.
- Undefined opcode: instruction 11111 executes as NOP. Required response: no strobes, no enable, and PC increments by 1.
- PC wrap: fill program memory with NOP except address 0 = HLT; run until PC reaches 0x7FF. Required response: the next PC is 0x000, the HLT fetched there halts the block, and the counter has not overflowed.
- Reset mid-MEM of an ADD: outputs clear on the next edge and o_enb_acc never pulses. Asserting i_start again re-fetches address 0.
